// File: rtl/vmicro16_uart_rx_apb.sv
// APB slave UART receiver (8 data bits, LSB first, 1 stop bit) with an RX FIFO and data-available irq.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking; the default build is 8N1.
module vmicro16_uart_rx_apb #(
  parameter int BUS_WIDTH  = 16,
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 irq
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // APB handshake: a transfer completes in the single access-phase cycle
  // (S_PSELx & S_PENABLE); S_PREADY is always high then, so no wait states.
  logic          apb_access;
  logic          rd_access;
  logic          wr_access;
  logic [1:0]    addr;

  logic          rx_meta;
  logic          rxs;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_err;
  logic          rx_push;
  logic [7:0]    rx_byte;
  logic          ferr_set;
  logic          perr_set;
  logic          timer_wrap;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovr_set;

  logic          ferr_flag;
  logic          ovr_flag;
  logic          perr_flag;
  logic [2:0]    clr;

  logic          unused_bits;

  assign apb_access = S_PSELx & S_PENABLE;
  assign rd_access  = apb_access & ~S_PWRITE;
  assign wr_access  = apb_access & S_PWRITE;
  assign addr       = S_PADDR[1:0];
  assign S_PREADY   = apb_access;

  assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[BUS_WIDTH-1:5], S_PWDATA[1:0]};

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_wire;
      rxs     <= rx_meta;
    end
  end

  assign timer_wrap = (timer == TW'(CPB - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_err  <= 1'b0;
      rx_push  <= 1'b0;
      rx_byte  <= '0;
      ferr_set <= 1'b0;
      perr_set <= 1'b0;
    end else begin
      rx_push  <= 1'b0;
      ferr_set <= 1'b0;
      perr_set <= 1'b0;
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          par_err <= 1'b0;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (timer == TW'(HALF)) begin
            timer <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer_wrap) begin
            timer   <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          // Even parity: the received bit must equal the XOR of the data bits.
          if (timer_wrap) begin
            timer <= '0;
            state <= S_STOP;
            if (rxs != ^shift) begin
              par_err  <= 1'b1;
              perr_set <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (timer_wrap) begin
            timer <= '0;
            state <= S_IDLE;
            if (rxs) begin
              rx_push <= ~par_err;
              rx_byte <= shift;
            end else begin
              ferr_set <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_access && (addr == 2'd0) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = rx_push && (!full || pop);
  assign ovr_set = rx_push && full && !pop;
  assign clr     = (wr_access && addr == 2'd1) ? S_PWDATA[4:2] : 3'b000;

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      irq       <= 1'b0;
      ferr_flag <= 1'b0;
      ovr_flag  <= 1'b0;
      perr_flag <= 1'b0;
    end else begin
      count <= count_next;
      irq   <= (count_next != '0);
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      // Set wins over a simultaneous write-1-to-clear.
      ferr_flag <= (ferr_flag & ~clr[0]) | ferr_set;
      ovr_flag  <= (ovr_flag  & ~clr[1]) | ovr_set;
      perr_flag <= (perr_flag & ~clr[2]) | perr_set;
    end
  end

  always_comb begin
    S_PRDATA = '0;
    if (apb_access) begin
      case (addr)
        2'd0: if (!empty) S_PRDATA[7:0] = mem[rd_ptr];
        2'd1: S_PRDATA[4:0] = {perr_flag, ovr_flag, ferr_flag, full, empty};
        2'd2: S_PRDATA[CW-1:0] = count;
        default: S_PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
// Self-checking bench for vmicro16_uart_rx_apb: table-driven frames plus corner-case sequences,
// with a queue model of the RX FIFO contents and sticky flags.
module tb_vmicro16_uart_rx_apb;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] paddr = '0;
  logic [15:0] pwdata = '0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        rx_wire = 1'b1;
  logic [15:0] prdata;
  logic        pready;
  logic        irq;

  always #5 clk = ~clk;

  vmicro16_uart_rx_apb #(
    .BUS_WIDTH(16), .CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable),
    .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .rx_wire(rx_wire), .irq(irq)
  );

  typedef struct {
    logic [7:0]  data;
    logic        stop_bit;
    logic [15:0] exp_status;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] exp_q[$];
  logic        m_ferr = 1'b0;
  logic        m_ovr  = 1'b0;
  logic        m_perr = 1'b0;
  int          irq_lat;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    return {11'd0, m_perr, m_ovr, m_ferr, (exp_q.size() == 8), (exp_q.size() == 0)};
  endfunction

  task automatic drive_bit(input logic val, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_wire = val;
    end
  endtask

  // Full frame; irq_lat records how many cycles after the stop-bit midpoint irq was first seen high.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    irq_lat = -1;
    drive_bit(1'b0, CPB);
    for (int b = 0; b < 8; b++) drive_bit(d[b], CPB);
    if (PAR_EN) drive_bit((^d) ^ par_flip, CPB);
    drive_bit(stop_bit, CPB / 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (irq && irq_lat < 0) irq_lat = i;
      rx_wire = (i < CPB / 2) ? stop_bit : 1'b1;
    end
    if (PAR_EN && par_flip) m_perr = 1'b1;
    if (!stop_bit) m_ferr = 1'b1;
    if (stop_bit && !(PAR_EN && par_flip)) begin
      if (exp_q.size() == 8) m_ovr = 1'b1;
      else exp_q.push_back({8'h00, d});
    end
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    paddr = {14'd0, a}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    check("pready_rd", {15'd0, pready}, 16'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    paddr = {14'd0, a}; pwrite = 1'b1; pwdata = d; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("pready_wr", {15'd0, pready}, 16'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic read_data(input string name);
    logic [15:0] d;
    logic [15:0] e;
    apb_read(2'd0, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
    check(name, d, e);
  endtask

  task automatic read_status(input string name, input logic [15:0] e);
    logic [15:0] d;
    apb_read(2'd1, d);
    check(name, d, e);
  endtask

  task automatic read_count(input string name);
    logic [15:0] d;
    apb_read(2'd2, d);
    check(name, d, 16'(exp_q.size()));
  endtask

  task automatic clear_flags();
    apb_write(2'd1, 16'h001C);
    m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    vecs[0] = '{8'h55, 1'b1, 16'h0001};
    vecs[1] = '{8'h00, 1'b1, 16'h0001};
    vecs[2] = '{8'hFF, 1'b1, 16'h0001};
    vecs[3] = '{8'h80, 1'b1, 16'h0001};
    vecs[4] = '{8'h3C, 1'b0, 16'h0005};
    vecs[5] = '{8'h01, 1'b1, 16'h0001};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_prdata", prdata, 16'h0000);
    check("rst_pready", {15'd0, pready}, 16'd0);
    check("rst_irq", {15'd0, irq}, 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_irq_after", {15'd0, irq}, 16'd0);
    read_count("rst_count");
    read_status("rst_status", 16'h0001);

    // Single byte A5
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t1_irq_latency", {15'd0, (irq_lat >= 0 && irq_lat <= 10)}, 16'd1);
    read_count("t1_count");
    read_data("t1_data");
    read_status("t1_status", 16'h0001);
    check("t1_irq_low", {15'd0, irq}, 16'd0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_bit, 1'b0);
      read_count($sformatf("vec%0d_count", v));
      while (exp_q.size() > 0) read_data($sformatf("vec%0d_data", v));
      read_status($sformatf("vec%0d_status", v), vecs[v].exp_status);
      clear_flags();
    end

    // Overflow: nine bytes, no reads
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("t2_irq", {15'd0, irq}, 16'd1);
    read_count("t2_count");
    read_status("t2_status", 16'h000A);
    check("t2_model_status", model_status(), 16'h000A);
    for (int i = 0; i < 8; i++) read_data($sformatf("t2_data%0d", i));
    read_data("t2_empty_data");
    apb_write(2'd1, 16'h0008);
    m_ovr = 1'b0;
    read_status("t2_status_clr", 16'h0001);

    // Framing error then a good byte
    send_frame(8'h3C, 1'b0, 1'b0);
    read_count("t3_count");
    check("t3_irq", {15'd0, irq}, 16'd0);
    read_status("t3_status", 16'h0005);
    send_frame(8'h3C, 1'b1, 1'b0);
    read_data("t3_data");
    clear_flags();
    read_status("t3_status_clr", 16'h0001);

    // Short glitch on the line
    @(negedge clk);
    rx_wire = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rx_wire = 1'b1;
    repeat (10) @(negedge clk);
    read_count("t4_count");
    read_status("t4_status", 16'h0001);
    send_frame(8'hFF, 1'b1, 1'b0);
    read_data("t4_data");
    read_status("t4_status_after", model_status());

`ifdef UART_RX_PARITY_EN
    // Parity error then a good parity frame
    send_frame(8'h07, 1'b1, 1'b1);
    read_count("t6_count");
    read_status("t6_status", 16'h0011);
    send_frame(8'h07, 1'b1, 1'b0);
    read_data("t6_data");
    clear_flags();
`endif

    // Reset in the middle of a frame with two bytes queued
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    read_count("t5_count_pre");
    check("t5_irq_pre", {15'd0, irq}, 16'd1);
    drive_bit(1'b0, CPB);
    for (int b = 0; b < 4; b++) drive_bit(1'(8'h81 >> b), CPB);
    drive_bit(1'b0, CPB / 2);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rx_wire = 1'b1;
    reset = 1'b0;
    exp_q.delete();
    m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_irq", {15'd0, irq}, 16'd0);
    check("t5_prdata", prdata, 16'h0000);
    read_count("t5_count");
    read_status("t5_status", 16'h0001);
    repeat (CPB * 12) @(negedge clk);
    read_count("t5_count_late");
    apb_read(2'd3, d);
    check("reserved_read", d, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
